// File: rtl/regfile_x31z.sv
// Integer register file, 32 x N bits, X31 hard-wired to zero; build option REGFILE_WRITE_BYPASS_EN.
// Latency: reads are combinational (zero cycles); writes land on the rising edge of clk.
// Backpressure: none; a write is accepted on every edge where it is enabled.
module regfile_x31z #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we3,
  input  logic [4:0]   ra1,
  input  logic [4:0]   ra2,
  input  logic [4:0]   wa3,
  input  logic [N-1:0] wd3,
  output logic [N-1:0] rd1,
  output logic [N-1:0] rd2
);

  // Register count is fixed by the 5-bit address; X31 has no storage.
  localparam int NREGS = 32;
  localparam int NSTORE = NREGS - 1;
  localparam logic [4:0] XZR = 5'd31;

  logic [N-1:0] regs_q [0:NSTORE-1];
  logic [N-1:0] regs_d [0:NSTORE-1];

  // A write to XZR is discarded, so it never counts as a real write.
  logic wr_real;
  assign wr_real = we3 && (wa3 != XZR);

  // Next-state: reset reloads each register with its own index and beats any write.
  always_comb begin
    for (int i = 0; i < NSTORE; i++) begin
      if (reset) begin
        regs_d[i] = N'(i);
      end else if (wr_real && (wa3 == 5'(i))) begin
        regs_d[i] = wd3;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Storage update on the rising edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NSTORE; i++) begin
      regs_q[i] <= regs_d[i];
    end
  end

`ifdef REGFILE_WRITE_BYPASS_EN
  // Same-cycle forwarding is suppressed during reset, since the write will not land.
  logic byp1, byp2;
  assign byp1 = !reset && wr_real && (ra1 == wa3);
  assign byp2 = !reset && wr_real && (ra2 == wa3);
`endif

  // Read port 1: XZR reads zero, otherwise stored value (or forwarded write data).
  always_comb begin
    rd1 = '0;
    if (ra1 != XZR) begin
      rd1 = regs_q[ra1];
    end
`ifdef REGFILE_WRITE_BYPASS_EN
    if (byp1) begin
      rd1 = wd3;
    end
`endif
  end

  // Read port 2: same behaviour as port 1.
  always_comb begin
    rd2 = '0;
    if (ra2 != XZR) begin
      rd2 = regs_q[ra2];
    end
`ifdef REGFILE_WRITE_BYPASS_EN
    if (byp2) begin
      rd2 = wd3;
    end
`endif
  end

endmodule

// File: tb/tb_regfile_x31z.sv
// Testbench for regfile_x31z: directed cases followed by randomized traffic.
// Expected read data comes from an array model of the register file and is queued per cycle.
// A negedge monitor pops the queue and compares against rd1/rd2.
module tb_regfile_x31z;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         we3 = 1'b0;
  logic [4:0]   ra1 = '0;
  logic [4:0]   ra2 = '0;
  logic [4:0]   wa3 = '0;
  logic [N-1:0] wd3 = '0;
  logic [N-1:0] rd1;
  logic [N-1:0] rd2;

  regfile_x31z #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .we3   (we3),
    .ra1   (ra1),
    .ra2   (ra2),
    .wa3   (wa3),
    .wd3   (wd3),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  always #5 clk = ~clk;

  // Reference model: plain array of the 31 real registers.
  logic [N-1:0] model [0:30];

  // Scoreboard queues filled by stimulus, drained by the monitor.
  logic [N-1:0] exp1_q [$];
  logic [N-1:0] exp2_q [$];
  string        name_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  // Value a read port should present given the current model and current inputs.
  function automatic logic [N-1:0] model_rd(input logic [4:0] ra, input logic rst,
                                            input logic we, input logic [4:0] wa,
                                            input logic [N-1:0] wd);
    logic [N-1:0] v;
    if (ra == 5'd31) begin
      v = '0;
    end else begin
      v = model[ra];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (!rst && we && wa != 5'd31 && ra == wa) v = wd;
`endif
    end
    return v;
  endfunction

  // Apply one cycle of inputs, optionally queue the expected reads, then commit the edge to the model.
  task automatic step(input logic rst, input logic we, input logic [4:0] a1,
                      input logic [4:0] a2, input logic [4:0] wa,
                      input logic [N-1:0] wd, input bit chk, input string nm);
    reset = rst; we3 = we; ra1 = a1; ra2 = a2; wa3 = wa; wd3 = wd;
    if (chk) begin
      exp1_q.push_back(model_rd(a1, rst, we, wa, wd));
      exp2_q.push_back(model_rd(a2, rst, we, wa, wd));
      name_q.push_back(nm);
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 31; i++) model[i] = N'(i);
    end else if (we && wa != 5'd31) begin
      model[wa] = wd;
    end
    #1;
  endtask

  // Monitor: one queued expectation is compared per negedge.
  initial begin
    logic [N-1:0] e1, e2;
    string nm;
    forever begin
      @(negedge clk);
      if (exp1_q.size() > 0) begin
        e1 = exp1_q.pop_front();
        e2 = exp2_q.pop_front();
        nm = name_q.pop_front();
        n_checks++;
        if (rd1 !== e1) begin
          n_fail++;
          $display("FAIL %s rd1 (ra1=%0d): got %h expected %h", nm, ra1, rd1, e1);
        end
        n_checks++;
        if (rd2 !== e2) begin
          n_fail++;
          $display("FAIL %s rd2 (ra2=%0d): got %h expected %h", nm, ra2, rd2, e2);
        end
      end
    end
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [4:0]   r_a1, r_a2, r_wa;
  logic [N-1:0] r_wd;
  logic         r_we, r_rst;
  int           drain;

  initial begin
    for (int i = 0; i < 31; i++) model[i] = N'(i);

    // Establish the defined initial contents.
    step(1'b1, 1'b0, 5'd0, 5'd31, 5'd0, '0, 1'b0, "reset");

    // Initial sweep of even/odd registers.
    for (int k = 0; k < 15; k++) begin
      step(1'b0, 1'b0, 5'(2*k), 5'(2*k+1), 5'd0, '0, 1'b1, "init_sweep");
    end
    step(1'b0, 1'b0, 5'd30, 5'd31, 5'd30, N'(507), 1'b1, "x30_xzr");
    step(1'b0, 1'b0, 5'd30, 5'd31, 5'd30, N'(507), 1'b1, "no_we_pulse");

    // Write x30 then read it back.
    step(1'b0, 1'b1, 5'd30, 5'd30, 5'd30, N'(507), 1'b1, "wr_x30_same_cycle");
    step(1'b0, 1'b0, 5'd30, 5'd29, 5'd0, '0, 1'b1, "rd_x30_after");

    // Write to XZR must be discarded.
    step(1'b0, 1'b1, 5'd31, 5'd31, 5'd31, N'(507), 1'b1, "wr_xzr_same");
    step(1'b0, 1'b0, 5'd31, 5'd30, 5'd0, '0, 1'b1, "rd_xzr_after");
    for (int k = 0; k < 31; k++) begin
      step(1'b0, 1'b0, 5'(k), 5'(30 - k), 5'd0, '0, 1'b1, "unchanged_sweep");
    end

    // Reset restores x30; reset beats a simultaneous write.
    step(1'b1, 1'b1, 5'd30, 5'd5, 5'd5, N'(99), 1'b0, "reset_with_write");
    step(1'b0, 1'b0, 5'd30, 5'd5, 5'd0, '0, 1'b1, "after_reset");

    // Read-during-write on x7 (forwarded only in the bypass build).
    step(1'b0, 1'b1, 5'd7, 5'd7, 5'd7, N'(16'hABCD), 1'b1, "rdw_x7");
    step(1'b0, 1'b0, 5'd7, 5'd6, 5'd0, '0, 1'b1, "rdw_x7_after");

    // Randomized traffic with bias toward address collisions, XZR and reset.
    for (int c = 0; c < 400; c++) begin
      r_rst = ($urandom_range(0, 39) == 0);
      r_we  = ($urandom_range(0, 3) != 0);
      r_wa  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      r_a1  = ($urandom_range(0, 2) == 0) ? r_wa : 5'($urandom_range(0, 31));
      r_a2  = ($urandom_range(0, 2) == 0) ? r_wa : 5'($urandom_range(0, 31));
      r_wd  = {$urandom, $urandom};
      step(r_rst, r_we, r_a1, r_a2, r_wa, r_wd, 1'b1, "random");
    end

    // Final readback of every address.
    for (int k = 0; k < 32; k++) begin
      step(1'b0, 1'b0, 5'(k), 5'(31 - k), 5'd0, '0, 1'b1, "final_sweep");
    end

    drain = 0;
    while (exp1_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    if (exp1_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp1_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
